// File: rtl/wb_pkg.sv
// Shared write-back definitions, also used by the register file.
// Optional feature macro used by this slice: WB_BYPASS_EN.
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ID_W   = 5;

  typedef struct packed {
    logic [WB_ID_W-1:0]   id;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order result storage: entries, power-of-two wrapping pointers and occupancy.
// With WB_BYPASS_EN defined, the raw entries and read pointer are exported for lookup.
module wb_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ID_W   = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [ID_W-1:0]          i_push_id,
  input  logic [DATA_W-1:0]        i_push_data,
  input  logic                     i_pop,
  output logic [ID_W-1:0]          o_head_id,
  output logic [DATA_W-1:0]        o_head_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
`ifdef WB_BYPASS_EN
  ,
  output logic [DEPTH-1:0][ID_W-1:0]   o_ids,
  output logic [DEPTH-1:0][DATA_W-1:0] o_data,
  output logic [$clog2(DEPTH)-1:0]     o_rd_ptr
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ID_W-1:0]   r_id   [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  assign o_count = r_count;
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);

  // A push at full or a pop at empty is ignored rather than corrupting state.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  assign o_head_id   = o_empty ? '0 : r_id[r_rd_ptr];
  assign o_head_data = o_empty ? '0 : r_data[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_id[r_wr_ptr]   <= i_push_id;
      r_data[r_wr_ptr] <= i_push_data;
    end
  end

`ifdef WB_BYPASS_EN
  assign o_rd_ptr = r_rd_ptr;
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      o_ids[k]  = r_id[k];
      o_data[k] = r_data[k];
    end
  end
`endif

endmodule

// File: rtl/wb_write_queue.sv
// Write-back queue: load/ALU arbitration, id-0 filter and always-on drain to the register file.
// Defining WB_BYPASS_EN adds the youngest-match lookup on q_id1/q_id2.
module wb_write_queue
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = WB_DATA_W,
  parameter int ID_W   = WB_ID_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [ID_W-1:0]        alu_id,
  input  logic [DATA_W-1:0]      alu_data,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [ID_W-1:0]        ld_id,
  input  logic [DATA_W-1:0]      ld_data,
  output logic                   wr_en,
  output logic [ID_W-1:0]        wr_id,
  output logic [DATA_W-1:0]      wr_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
`ifdef WB_BYPASS_EN
  input  logic [ID_W-1:0]        q_id1,
  input  logic [ID_W-1:0]        q_id2,
`endif
  output logic                   hit1,
  output logic                   hit2,
  output logic [DATA_W-1:0]      hit_data1,
  output logic [DATA_W-1:0]      hit_data2
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic              w_ld_fire;
  logic              w_alu_fire;
  logic              w_push;
  logic [ID_W-1:0]   w_push_id;
  logic [DATA_W-1:0] w_push_data;

  // Handshake: a producer's result transfers on a rising edge where its valid and
  // ready are both high. Ready depends only on occupancy and ld_valid, so load wins.
  assign ld_ready  = !full;
  assign alu_ready = !full && !ld_valid;

  assign w_ld_fire   = ld_valid && ld_ready;
  assign w_alu_fire  = alu_valid && alu_ready;
  assign w_push_id   = w_ld_fire ? ld_id : alu_id;
  assign w_push_data = w_ld_fire ? ld_data : alu_data;
  // Writes to register 0 are accepted but dropped here.
  assign w_push      = (w_ld_fire || w_alu_fire) && (w_push_id != '0);

`ifdef WB_BYPASS_EN
  logic [DEPTH-1:0][ID_W-1:0]   w_ids;
  logic [DEPTH-1:0][DATA_W-1:0] w_datas;
  logic [PTR_W-1:0]             w_rd_ptr;
`endif

  wb_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ID_W   (ID_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_id   (w_push_id),
    .i_push_data (w_push_data),
    .i_pop       (!empty),
    .o_head_id   (wr_id),
    .o_head_data (wr_data),
    .o_count     (count),
    .o_full      (full),
    .o_empty     (empty)
`ifdef WB_BYPASS_EN
    ,
    .o_ids       (w_ids),
    .o_data      (w_datas),
    .o_rd_ptr    (w_rd_ptr)
`endif
  );

  assign wr_en = !empty;

`ifdef WB_BYPASS_EN
  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    logic [PTR_W-1:0] w_idx;
    hit1      = 1'b0;
    hit2      = 1'b0;
    hit_data1 = '0;
    hit_data2 = '0;
    w_idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = w_rd_ptr + PTR_W'(k);
      if (CNT_W'(k) < count) begin
        if ((q_id1 != '0) && (w_ids[w_idx] == q_id1)) begin
          hit1      = 1'b1;
          hit_data1 = w_datas[w_idx];
        end
        if ((q_id2 != '0) && (w_ids[w_idx] == q_id2)) begin
          hit2      = 1'b1;
          hit_data2 = w_datas[w_idx];
        end
      end
    end
  end
`else
  assign hit1      = 1'b0;
  assign hit2      = 1'b0;
  assign hit_data1 = '0;
  assign hit_data2 = '0;
`endif

endmodule

// File: doc/wb_write_queue.md
# wb_write_queue

Write-back queue on the register file's write port of the MIPS datapath. Accepts completed results from two producers, the ALU and the load unit, through valid/ready handshakes. Buffers them in a small in-order FIFO and drains one entry per cycle onto the register file write port (write enable, destination id, write data). Optionally provides a lookup so the register file read ports can see results still queued.

## Interface
Parameters:
- DEPTH, 4 — FIFO entries; power of two, at least 2
- DATA_W, 32 — result width
- ID_W, 5 — register id width

Ports:
- clk  in  1  — single clock, rising edge
- rst_n  in  1  — asynchronous, active-low reset
- alu_valid  in  1  — ALU result offered
- alu_ready  out  1  — ALU result accepted this edge when both valid and ready are high
- alu_id  in  ID_W  — ALU destination register
- alu_data  in  DATA_W  — ALU result
- ld_valid  in  1  — load result offered
- ld_ready  out  1  — load handshake ready
- ld_id  in  ID_W  — load destination register
- ld_data  in  DATA_W  — load result
- wr_en  out  1  — register file write enable
- wr_id  out  ID_W  — register file write id
- wr_data  out  DATA_W  — register file write data
- count  out  $clog2(DEPTH)+1  — occupancy
- full  out  1  — count == DEPTH
- empty  out  1  — count == 0
- q_id1, q_id2  in  ID_W  — bypass lookup ids (only with bypass compiled in)
- hit1, hit2  out  1  — lookup hit
- hit_data1, hit_data2  out  DATA_W  — youngest queued data for the lookup id

## Operation
- At most one enqueue per cycle. Load has priority over ALU.
  - ld_ready = !full.
  - alu_ready = !full && !ld_valid.
  - Both ready signals depend only on registered state and ld_valid, never on the drain path.
- A result with id 0 is handshaken normally but never stored: no count change, no write.
- Drain: whenever !empty, wr_en=1 and wr_id/wr_data come combinationally from the head entry. The head pops at the same edge. The register file always accepts.
- Push and pop in the same edge: count unchanged, order preserved.
- Pointers are ID-width-independent, log2(DEPTH) bits each, and wrap modulo DEPTH. Full and empty are derived from count.
- While empty, wr_id=0 and wr_data=0.

## Timing
- Reset, asynchronous, active low:
  - pointers=0, count=0, empty=1, full=0, wr_en=0
  - hit1/hit2=0; stored entries are don't-care
- Reset asserted mid-operation discards all queued entries immediately. No write is issued after reset assertion.
- Latency: a result accepted at edge N appears on wr_* during cycle N..N+1 and is written by the register file at edge N+1, provided it is at the head.
- Throughput: one write per cycle sustained. With one result per cycle, occupancy stays at or below 1.
- At full, both ready signals are low. They go high the cycle after the drain pop.

## Configuration
- WB_BYPASS_EN defined:
  - Each lookup compares q_id against all valid entries, head included.
  - The youngest match wins: hitN=1, hit_dataN = that entry's data.
  - Lookup is combinational with zero latency. q_id=0 never hits.
- WB_BYPASS_EN undefined: the q_id ports are absent, hit outputs are tied to 0, and no compare logic is generated.

## Structure
- Shared package wb_pkg:
  - wb_entry_t struct {id, data}
  - constants WB_DATA_W=32 and WB_ID_W=5, shared with the register file
- One sub-module, wb_fifo: storage, pointers and count. The top level holds the arbitration, the id-0 filter and the bypass search.

## Test plan
- Reset, then a single ALU result alu_id=3, alu_data=32'hFFFF_FFFF → next cycle wr_en=1, wr_id=3, wr_data=32'hFFFF_FFFF; then empty=1.
- ld_valid and alu_valid high together (ld id 4 = 32'h1111_1114, alu id 2 = 32'h1111_1112) → ld accepted first, alu_ready=0. ALU accepted the next cycle. Writes occur in order 4, then 2.
- Drain stalled by back-to-back pushes is impossible, so fill via a reset-timed burst or a forced FIFO-only test. Check: at count=4, full=1 and both ready=0. Ready returns the cycle after a pop. No entry is lost or duplicated across pointer wrap (≥10 entries).
- Push with id 0 and data 32'hDEAD_BEEF → handshake completes, count stays 0, wr_en never asserted.
- WB_BYPASS_EN: queue id 5 = 32'hA, then id 5 = 32'hB. Result: q_id1=5 → hit1=1, hit_data1=32'hB; q_id2=6 → hit2=0.
- rst_n dropped while count=3 → count=0 and wr_en=0 immediately; no writes after release until new pushes.
